// File: rtl/sys_ctrl_mb.sv
// System controller: decodes UART command frames into register-file writes/reads and ALU
// operations, then serialises read or ALU results LSB-first into the TX FIFO.
module sys_ctrl_mb #(
    parameter int WIDTH_REG = 8,
    parameter int ADDR      = 4,
    parameter int FUN       = 4,
    parameter int ALU_BYTES = 2,
    parameter int TIMEOUT   = 1023,
    parameter logic [WIDTH_REG-1:0] CMD_WR      = 8'hAA,
    parameter logic [WIDTH_REG-1:0] CMD_RD      = 8'hBB,
    parameter logic [WIDTH_REG-1:0] CMD_ALU_OP  = 8'hCC,
    parameter logic [WIDTH_REG-1:0] CMD_ALU_NOP = 8'hDD
) (
    input  logic                           i_Ref_clk,
    input  logic                           i_rst,
    input  logic [WIDTH_REG-1:0]           i_sync_P_Data,
    input  logic                           i_Vid_D_Sync,
    input  logic [WIDTH_REG-1:0]           i_Rd_D_REG,
    input  logic                           i_Vid_Rd,
    input  logic [WIDTH_REG*ALU_BYTES-1:0] i_ALU_out,
    input  logic                           i_Vid_ALU,
    input  logic                           i_FIFO_Full,
    output logic                           o_wr_en,
    output logic                           o_rd_en,
    output logic [ADDR-1:0]                o_adder,
    output logic [WIDTH_REG-1:0]           o_Wr_D_REG,
    output logic [FUN-1:0]                 o_fun,
    output logic                           o_ALU_EN,
    output logic                           o_Gate_EN,
    output logic                           o_Div_EN,
    output logic                           o_WR_INC,
    output logic [WIDTH_REG-1:0]           o_WR_D_FIFO,
    output logic                           o_err_cmd,
    output logic                           o_err_tmo,
    output logic                           o_busy
);
    localparam int RW = WIDTH_REG * ALU_BYTES;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : {TW{1'b0}};
    localparam bit TMO_ON = (TIMEOUT > 0);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_WR_ADDR  = 4'd1,
        S_WR_DATA  = 4'd2,
        S_RD_ADDR  = 4'd3,
        S_RD_WAIT  = 4'd4,
        S_OPA      = 4'd5,
        S_OPB      = 4'd6,
        S_FUN      = 4'd7,
        S_ALU_WAIT = 4'd8,
        S_TX       = 4'd9
    } state_t;

    state_t                r_state, w_next;
    logic [TW-1:0]         r_tmo_cnt, w_tmo_cnt;
    logic [RW-1:0]         r_shift, w_shift;
    logic [3:0]            r_cnt, w_cnt;
    logic [ADDR-1:0]       r_addr, w_addr;
    logic                  r_wr_en, w_wr_en, r_rd_en, w_rd_en;
    logic [ADDR-1:0]       r_adder, w_adder;
    logic [WIDTH_REG-1:0]  r_wr_d, w_wr_d;
    logic [FUN-1:0]        r_fun, w_fun;
    logic                  r_alu_en, w_alu_en, r_gate_en, w_gate_en;
    logic                  r_err_cmd, w_err_cmd, r_err_tmo, w_err_tmo;
    logic                  r_busy, r_div_en;
    logic                  w_timed, w_wr_inc;

    // State register
    always_ff @(posedge i_Ref_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state, datapath and next-output decode
    always_comb begin
        w_next    = r_state;
        w_tmo_cnt = r_tmo_cnt;
        w_shift   = r_shift;
        w_cnt     = r_cnt;
        w_addr    = r_addr;
        w_wr_en   = 1'b0;
        w_rd_en   = 1'b0;
        w_adder   = r_adder;
        w_wr_d    = r_wr_d;
        w_fun     = r_fun;
        w_alu_en  = r_alu_en;
        w_gate_en = r_gate_en;
        w_err_cmd = 1'b0;
        w_err_tmo = 1'b0;
        w_timed   = 1'b0;
        w_wr_inc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_Vid_D_Sync) begin
                    case (i_sync_P_Data)
                        CMD_WR:      w_next = S_WR_ADDR;
                        CMD_RD:      w_next = S_RD_ADDR;
                        CMD_ALU_OP:  w_next = S_OPA;
                        CMD_ALU_NOP: w_next = S_FUN;
                        default:     w_err_cmd = 1'b1;
                    endcase
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_WR_ADDR: begin
                w_timed = 1'b1;
                if (i_Vid_D_Sync) begin
                    w_addr = i_sync_P_Data[ADDR-1:0];
                    w_next = S_WR_DATA;
                end else begin
                    w_next = S_WR_ADDR;
                end
            end
            S_WR_DATA: begin
                w_timed = 1'b1;
                if (i_Vid_D_Sync) begin
                    w_wr_en = 1'b1;
                    w_adder = r_addr;
                    w_wr_d  = i_sync_P_Data;
                    w_next  = S_IDLE;
                end else begin
                    w_next = S_WR_DATA;
                end
            end
            S_RD_ADDR: begin
                w_timed = 1'b1;
                if (i_Vid_D_Sync) begin
                    w_rd_en = 1'b1;
                    w_adder = i_sync_P_Data[ADDR-1:0];
                    w_next  = S_RD_WAIT;
                end else begin
                    w_next = S_RD_ADDR;
                end
            end
            S_RD_WAIT: begin
                if (i_Vid_Rd) begin
                    w_shift = RW'(i_Rd_D_REG);
                    w_cnt   = 4'd1;
                    w_next  = S_TX;
                end else begin
                    w_next = S_RD_WAIT;
                end
            end
            S_OPA, S_OPB: begin
                w_timed = 1'b1;
                if (i_Vid_D_Sync) begin
                    w_wr_en = 1'b1;
                    w_wr_d  = i_sync_P_Data;
                    w_adder = (r_state == S_OPA) ? {ADDR{1'b0}} : ADDR'(1);
                    w_gate_en = (r_state == S_OPB) ? 1'b1 : r_gate_en;
                    w_next  = (r_state == S_OPA) ? S_OPB : S_FUN;
                end else begin
                    w_next = r_state;
                end
            end
            S_FUN: begin
                w_timed = 1'b1;
                if (i_Vid_D_Sync) begin
                    w_gate_en = 1'b1;
                    w_fun     = i_sync_P_Data[FUN-1:0];
                    w_alu_en  = 1'b1;
                    w_next    = S_ALU_WAIT;
                end else begin
                    w_next = S_FUN;
                end
            end
            S_ALU_WAIT: begin
                if (i_Vid_ALU) begin
                    w_shift   = i_ALU_out;
                    w_cnt     = 4'(ALU_BYTES);
                    w_alu_en  = 1'b0;
                    w_gate_en = 1'b0;
                    w_next    = S_TX;
                end else begin
                    w_next = S_ALU_WAIT;
                end
            end
            S_TX: begin
                w_wr_inc = !i_FIFO_Full;
                if (w_wr_inc) begin
                    w_shift = r_shift >> WIDTH_REG;
                    w_cnt   = r_cnt - 4'd1;
                    w_next  = (r_cnt == 4'd1) ? S_IDLE : S_TX;
                end else begin
                    w_next = S_TX;
                end
            end
            default: w_next = S_IDLE;
        endcase
        // Inter-byte timeout only guards states that are waiting on the host
        if (w_timed && TMO_ON) begin
            if (i_Vid_D_Sync) begin
                w_tmo_cnt = {TW{1'b0}};
            end else if (r_tmo_cnt == TMO_LAST) begin
                w_tmo_cnt = {TW{1'b0}};
                w_next    = S_IDLE;
                w_err_tmo = 1'b1;
                w_gate_en = 1'b0;
            end else begin
                w_tmo_cnt = r_tmo_cnt + TW'(1);
            end
        end else begin
            w_tmo_cnt = {TW{1'b0}};
        end
    end

    // Datapath and registered control outputs
    always_ff @(posedge i_Ref_clk) begin
        if (!i_rst) begin
            r_tmo_cnt <= {TW{1'b0}};
            r_shift   <= {RW{1'b0}};
            r_cnt     <= 4'd0;
            r_addr    <= {ADDR{1'b0}};
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_adder   <= {ADDR{1'b0}};
            r_wr_d    <= {WIDTH_REG{1'b0}};
            r_fun     <= {FUN{1'b0}};
            r_alu_en  <= 1'b0;
            r_gate_en <= 1'b0;
            r_err_cmd <= 1'b0;
            r_err_tmo <= 1'b0;
            r_busy    <= 1'b0;
            r_div_en  <= 1'b1;
        end else begin
            r_tmo_cnt <= w_tmo_cnt;
            r_shift   <= w_shift;
            r_cnt     <= w_cnt;
            r_addr    <= w_addr;
            r_wr_en   <= w_wr_en;
            r_rd_en   <= w_rd_en;
            r_adder   <= w_adder;
            r_wr_d    <= w_wr_d;
            r_fun     <= w_fun;
            r_alu_en  <= w_alu_en;
            r_gate_en <= w_gate_en;
            r_err_cmd <= w_err_cmd;
            r_err_tmo <= w_err_tmo;
            r_busy    <= (w_next != S_IDLE);
            r_div_en  <= 1'b1;
        end
    end

    assign o_wr_en     = r_wr_en;
    assign o_rd_en     = r_rd_en;
    assign o_adder     = r_adder;
    assign o_Wr_D_REG  = r_wr_d;
    assign o_fun       = r_fun;
    assign o_ALU_EN    = r_alu_en;
    assign o_Gate_EN   = r_gate_en;
    assign o_Div_EN    = r_div_en;
    assign o_err_cmd   = r_err_cmd;
    assign o_err_tmo   = r_err_tmo;
    assign o_busy      = r_busy;
    assign o_WR_INC    = w_wr_inc;
    assign o_WR_D_FIFO = r_shift[WIDTH_REG-1:0];
endmodule

// File: tb/tb_sys_ctrl_mb.sv
// Bench for sys_ctrl_mb: table of command frames checked against scoreboard queues for RF
// writes and FIFO bytes, plus hand-written FIFO-stall, timeout and mid-frame reset sequences.
module tb_sys_ctrl_mb;
    localparam int TMO = 32;
    localparam int K_WR = 0, K_RD = 1, K_ALU = 2, K_NOP = 3, K_BAD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  sync_data = 8'h00;
    logic        vid_sync = 1'b0;
    logic [7:0]  rd_data = 8'h00;
    logic        vid_rd = 1'b0;
    logic [15:0] alu_out = 16'h0000;
    logic        vid_alu = 1'b0;
    logic        fifo_full = 1'b0;
    logic        wr_en, rd_en, alu_en, gate_en, div_en, wr_inc, err_cmd, err_tmo, busy;
    logic [3:0]  adder, fun;
    logic [7:0]  wr_d, fifo_d;

    sys_ctrl_mb #(.TIMEOUT(TMO)) dut (
        .i_Ref_clk(clk), .i_rst(rst), .i_sync_P_Data(sync_data), .i_Vid_D_Sync(vid_sync),
        .i_Rd_D_REG(rd_data), .i_Vid_Rd(vid_rd), .i_ALU_out(alu_out), .i_Vid_ALU(vid_alu),
        .i_FIFO_Full(fifo_full), .o_wr_en(wr_en), .o_rd_en(rd_en), .o_adder(adder),
        .o_Wr_D_REG(wr_d), .o_fun(fun), .o_ALU_EN(alu_en), .o_Gate_EN(gate_en),
        .o_Div_EN(div_en), .o_WR_INC(wr_inc), .o_WR_D_FIFO(fifo_d), .o_err_cmd(err_cmd),
        .o_err_tmo(err_tmo), .o_busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [7:0]  b0, b1, b2, b3;
        int          nb;
        logic [15:0] resp;
        bit          junk;
    } vec_t;

    vec_t        vecs[9];
    logic [11:0] wr_q[$];
    logic [7:0]  fifo_q[$];
    int          n_vec = 0, n_miss = 0;
    int          n_cmd_seen = 0, n_tmo_seen = 0, exp_cmd = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops expected RF writes and FIFO bytes as the DUT emits them
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (wr_q.size() == 0) chk("rf_write_unexpected", 32'({adder, wr_d}), 32'hFFFFFFFF);
            else chk("rf_write", 32'({adder, wr_d}), 32'(wr_q.pop_front()));
        end
        if (wr_inc === 1'b1) begin
            if (fifo_q.size() == 0) chk("fifo_unexpected", 32'(fifo_d), 32'hFFFFFFFF);
            else chk("fifo_byte", 32'(fifo_d), 32'(fifo_q.pop_front()));
        end
        if (err_cmd === 1'b1) n_cmd_seen++;
        if (err_tmo === 1'b1) n_tmo_seen++;
    end

    task automatic send_byte(input logic [7:0] b);
        sync_data = b;
        vid_sync  = 1'b1;
        @(posedge clk); #1;
        vid_sync  = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy !== 1'b0 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("idle_reached", 32'(busy), 32'h0);
        repeat (2) begin @(posedge clk); #1; end
        chk("wr_q_drained", 32'(wr_q.size()), 32'h0);
        chk("fifo_q_drained", 32'(fifo_q.size()), 32'h0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'h0);
        chk({tag, "_rd_en"}, 32'(rd_en), 32'h0);
        chk({tag, "_adder"}, 32'(adder), 32'h0);
        chk({tag, "_wr_d"}, 32'(wr_d), 32'h0);
        chk({tag, "_fun"}, 32'(fun), 32'h0);
        chk({tag, "_alu_en"}, 32'(alu_en), 32'h0);
        chk({tag, "_gate_en"}, 32'(gate_en), 32'h0);
        chk({tag, "_div_en"}, 32'(div_en), 32'h1);
        chk({tag, "_wr_inc"}, 32'(wr_inc), 32'h0);
        chk({tag, "_fifo_d"}, 32'(fifo_d), 32'h0);
        chk({tag, "_err_cmd"}, 32'(err_cmd), 32'h0);
        chk({tag, "_err_tmo"}, 32'(err_tmo), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fb[4];
        logic [7:0] fbyte;
        vec_t v;
        vecs[0] = '{K_WR,  8'hAA, 8'h05, 8'h3C, 8'h00, 3, 16'h0000, 1'b0};
        vecs[1] = '{K_WR,  8'hAA, 8'hF5, 8'h81, 8'h00, 3, 16'h0000, 1'b0};
        vecs[2] = '{K_RD,  8'hBB, 8'h05, 8'h00, 8'h00, 2, 16'h003C, 1'b0};
        vecs[3] = '{K_RD,  8'hBB, 8'h0A, 8'h00, 8'h00, 2, 16'h00C3, 1'b1};
        vecs[4] = '{K_ALU, 8'hCC, 8'h12, 8'h34, 8'h02, 4, 16'hABCD, 1'b0};
        vecs[5] = '{K_ALU, 8'hCC, 8'hFF, 8'h00, 8'h1F, 4, 16'h5AA5, 1'b1};
        vecs[6] = '{K_NOP, 8'hDD, 8'h07, 8'h00, 8'h00, 2, 16'h1234, 1'b0};
        vecs[7] = '{K_BAD, 8'hEE, 8'h00, 8'h00, 8'h00, 1, 16'h0000, 1'b0};
        vecs[8] = '{K_BAD, 8'h00, 8'h00, 8'h00, 8'h00, 1, 16'h0000, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            fb[0] = v.b0; fb[1] = v.b1; fb[2] = v.b2; fb[3] = v.b3;
            if (v.kind == K_WR) wr_q.push_back({v.b1[3:0], v.b2});
            if (v.kind == K_ALU) begin
                wr_q.push_back({4'h0, v.b1});
                wr_q.push_back({4'h1, v.b2});
            end
            for (int j = 0; j < v.nb; j++) send_byte(fb[j]);
            case (v.kind)
                K_RD: begin
                    chk("rd_en", 32'(rd_en), 32'h1);
                    chk("rd_addr", 32'(adder), 32'(v.b1[3:0]));
                    if (v.junk) send_byte(8'hAA);
                    fifo_q.push_back(v.resp[7:0]);
                    rd_data = v.resp[7:0];
                    vid_rd  = 1'b1;
                    @(posedge clk); #1;
                    vid_rd  = 1'b0;
                end
                K_ALU, K_NOP: begin
                    fbyte = (v.kind == K_ALU) ? v.b3 : v.b1;
                    chk("alu_en_set", 32'(alu_en), 32'h1);
                    chk("gate_en_set", 32'(gate_en), 32'h1);
                    chk("alu_fun", 32'(fun), 32'(fbyte[3:0]));
                    if (v.junk) send_byte(8'hBB);
                    chk("alu_fun_held", 32'(fun), 32'(fbyte[3:0]));
                    fifo_q.push_back(v.resp[7:0]);
                    fifo_q.push_back(v.resp[15:8]);
                    alu_out = v.resp;
                    vid_alu = 1'b1;
                    @(posedge clk); #1;
                    vid_alu = 1'b0;
                    chk("alu_en_drop", 32'(alu_en), 32'h0);
                    chk("gate_en_drop", 32'(gate_en), 32'h0);
                end
                K_BAD: begin
                    exp_cmd++;
                    chk("err_cmd_pulse", 32'(err_cmd), 32'h1);
                    chk("bad_cmd_busy", 32'(busy), 32'h0);
                end
                default: ;
            endcase
            wait_idle();
            chk("err_cmd_count", 32'(n_cmd_seen), 32'(exp_cmd));
        end

        // FIFO full stalls the second ALU byte with data held stable
        wr_q.push_back({4'h0, 8'h12});
        wr_q.push_back({4'h1, 8'h34});
        send_byte(8'hCC); send_byte(8'h12); send_byte(8'h34); send_byte(8'h02);
        fifo_q.push_back(8'hCD);
        fifo_q.push_back(8'hAB);
        alu_out = 16'hABCD;
        vid_alu = 1'b1;
        @(posedge clk); #1;
        vid_alu = 1'b0;
        @(posedge clk); #1;
        fifo_full = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("full_no_inc", 32'(wr_inc), 32'h0);
            chk("full_data_held", 32'(fifo_d), 32'hAB);
            @(posedge clk); #1;
        end
        fifo_full = 1'b0;
        wait_idle();

        // Frame timeout: no RF write, one o_err_tmo pulse
        send_byte(8'hAA); send_byte(8'h05);
        repeat (TMO - 1) begin @(posedge clk); #1; end
        chk("tmo_not_yet_busy", 32'(busy), 32'h1);
        chk("tmo_not_yet_err", 32'(err_tmo), 32'h0);
        @(posedge clk); #1;
        chk("tmo_err_pulse", 32'(err_tmo), 32'h1);
        chk("tmo_idle", 32'(busy), 32'h0);
        @(posedge clk); #1;
        chk("tmo_pulse_width", 32'(err_tmo), 32'h0);
        wait_idle();
        chk("tmo_count", 32'(n_tmo_seen), 32'h1);

        // Reset in ALU_WAIT aborts the frame; a following write completes
        wr_q.push_back({4'h0, 8'h12});
        wr_q.push_back({4'h1, 8'h34});
        send_byte(8'hCC); send_byte(8'h12); send_byte(8'h34); send_byte(8'h02);
        chk("pre_reset_alu_en", 32'(alu_en), 32'h1);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk_reset_outputs("midrst");
        repeat (2) begin @(posedge clk); #1; end
        wr_q.push_back({4'h1, 8'hFF});
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'hFF);
        wait_idle();
        chk("final_err_cmd_count", 32'(n_cmd_seen), 32'(exp_cmd));
        chk("final_tmo_count", 32'(n_tmo_seen), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
